// File: rtl/fifo_rd_ctrl_if.sv
// Stream, status and fifomem port bundle for fifo_rd_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATASIZE-1:0]   s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATASIZE-1:0]   m_data;
  logic [ADDRSIZE+1:0]   level;
  logic                  almost_full;
  logic                  mem_wclken;
  logic [ADDRSIZE-1:0]   mem_waddr;
  logic [DATASIZE-1:0]   mem_wdata;
  logic                  mem_wfull;
  logic                  mem_rclken;
  logic [ADDRSIZE-1:0]   mem_raddr;
  logic [DATASIZE-1:0]   mem_rdata;

  modport slave (
    input  flush, s_valid, s_data, m_ready, mem_rdata,
    output s_ready, m_valid, m_data, level, almost_full,
           mem_wclken, mem_waddr, mem_wdata, mem_wfull,
           mem_rclken, mem_raddr
  );

  modport master (
    output flush, s_valid, s_data, m_ready, mem_rdata,
    input  s_ready, m_valid, m_data, level, almost_full,
           mem_wclken, mem_waddr, mem_wdata, mem_wfull,
           mem_rclken, mem_raddr
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO controller for a registered-read fifomem; a 2-entry output buffer
// turns the 1-cycle read latency into a first-word-fall-through stream.
module fifo_rd_ctrl #(
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rd_ctrl_if.slave  bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
  localparam int LW    = ADDRSIZE + 2;

  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d, mem_cnt;
  logic                        rd_pend_q, rd_pend_d;
  logic [1:0]                  out_cnt_q, out_cnt_d, cnt_after;
  logic [1:0][DATASIZE-1:0]    obuf_q, obuf_d;
  logic                        mem_full, mem_empty, push, pop, issue;
  logic [2:0]                  credit;
  logic [LW-1:0]               level;

  assign mem_cnt   = wr_q - rd_q;
  assign mem_full  = (mem_cnt == PW'(DEPTH));
  assign mem_empty = (mem_cnt == '0);

  assign bus.s_ready = !rst && !mem_full;
  assign bus.m_valid = (out_cnt_q != 2'd0);
  assign bus.m_data  = obuf_q[0];

  assign push = bus.s_valid && !rst && !mem_full && !bus.flush;
  assign pop  = bus.m_valid && bus.m_ready;

  // Free buffer slots once this cycle's pop and any in-flight read are counted.
  assign credit = 3'd2 - {1'b0, out_cnt_q} - {2'b0, rd_pend_q} + {2'b0, pop};
  assign issue  = !rst && !bus.flush && !mem_empty && (credit != 3'd0) && !credit[2];

  assign level = LW'(mem_cnt) + LW'(rd_pend_q) + LW'(out_cnt_q);
  assign bus.level       = level;
  assign bus.almost_full = (level >= LW'(AFULL_LEVEL));

  assign bus.mem_wclken = push;
  assign bus.mem_waddr  = wr_q[ADDRSIZE-1:0];
  assign bus.mem_wdata  = bus.s_data;
  assign bus.mem_wfull  = mem_full;
  assign bus.mem_rclken = issue;
  assign bus.mem_raddr  = rd_q[ADDRSIZE-1:0];

  always_comb begin
    wr_d      = wr_q + PW'(push);
    rd_d      = rd_q + PW'(issue);
    rd_pend_d = issue;
    out_cnt_d = out_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    obuf_d    = obuf_q;
    cnt_after = out_cnt_q - {1'b0, pop};
    if (pop) obuf_d[0] = obuf_q[1];
    // With a read pending at most one word survives the pop, so the tail is slot 0 or 1.
    if (rd_pend_q) obuf_d[cnt_after[0]] = bus.mem_rdata;
    if (bus.flush) begin
      wr_d      = '0;
      rd_d      = '0;
      rd_pend_d = 1'b0;
      out_cnt_d = 2'd0;
      obuf_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      rd_pend_q <= 1'b0;
      out_cnt_q <= 2'd0;
      obuf_q    <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
      out_cnt_q <= out_cnt_d;
      obuf_q    <= obuf_d;
    end
  end

  // Buffered plus in-flight words must never exceed the two buffer slots.
  always_ff @(posedge clk) begin
    if (!rst) assert ({1'b0, out_cnt_q} + {2'b0, rd_pend_q} <= 3'd2);
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a registered-read memory model and
// a queue scoreboard checked at every negedge.
module tb_fifo_rd_ctrl;
  logic clk, rst;
  int   ntot, npass, nfail, npop;
  logic stall_q;
  logic [7:0] held;
  logic [7:0] sb[$];
  logic [7:0] mem [16];

  fifo_rd_ctrl_if #(.DATASIZE(8), .ADDRSIZE(4)) ifc();

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_LEVEL(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifc.mem_wclken && !ifc.mem_wfull) mem[ifc.mem_waddr] <= ifc.mem_wdata;
    if (ifc.mem_rclken) ifc.mem_rdata <= mem[ifc.mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (rst || ifc.flush) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", ifc.m_valid, 1);
        chk("hold_data", ifc.m_data, held);
      end
      if (ifc.m_valid && ifc.m_ready) begin
        npop++;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("order", ifc.m_data, sb.pop_front());
      end
      if (ifc.s_valid && ifc.s_ready) sb.push_back(ifc.s_data);
      chk("level_bound", 32'(ifc.level <= 18), 1);
      stall_q = ifc.m_valid && !ifc.m_ready;
      held    = ifc.m_data;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, guard;
    ntot = 0; npass = 0; nfail = 0; npop = 0;
    stall_q = 1'b0; held = '0;
    rst = 1'b1;
    ifc.flush = 1'b0; ifc.s_valid = 1'b1; ifc.s_data = 8'h11; ifc.m_ready = 1'b1;
    #1;
    chk("rst_s_ready", ifc.s_ready, 0);
    chk("rst_m_valid", ifc.m_valid, 0);
    chk("rst_level", ifc.level, 0);
    chk("rst_wclken", ifc.mem_wclken, 0);
    chk("rst_rclken", ifc.mem_rclken, 0);
    chk("rst_afull", ifc.almost_full, 0);
    repeat (3) cyc();
    ifc.s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_s_ready", ifc.s_ready, 1);
    chk("idle_m_valid", ifc.m_valid, 0);
    chk("idle_level", ifc.level, 0);
    chk("idle_wclken", ifc.mem_wclken, 0);
    chk("idle_rclken", ifc.mem_rclken, 0);
    cyc();

    // single word, 3-edge latency
    ifc.s_valid = 1'b1; ifc.s_data = 8'hA5; ifc.m_ready = 1'b1;
    cyc();
    ifc.s_valid = 1'b0;
    #1 chk("sw_lat_e0", ifc.m_valid, 0);
    cyc();
    #1 chk("sw_lat_e1", ifc.m_valid, 0);
    cyc();
    #1 chk("sw_valid_e2", ifc.m_valid, 1);
    chk("sw_data", ifc.m_data, 8'hA5);
    cyc();
    #1 chk("sw_level0", ifc.level, 0);
    chk("sw_empty", ifc.m_valid, 0);

    // fill to DEPTH+2 with consumer stalled
    ifc.m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ifc.s_valid = 1'b1; ifc.s_data = 8'(i);
      #1;
      chk("fill_ready", ifc.s_ready, 1);
      chk("fill_level", ifc.level, i);
      chk("fill_afull", ifc.almost_full, 32'(i >= 14));
      cyc();
    end
    ifc.s_data = 8'h99;
    #1;
    chk("full_ready", ifc.s_ready, 0);
    chk("full_level", ifc.level, 18);
    chk("full_afull", ifc.almost_full, 1);
    cyc();
    ifc.s_valid = 1'b0; ifc.m_ready = 1'b1;
    #1 chk("drain_ready0", ifc.s_ready, 0);
    cyc();
    #1 chk("drain_rearm", ifc.s_ready, 1);
    repeat (20) cyc();
    chk("drain_level", ifc.level, 0);
    chk("drain_sb", sb.size(), 0);

    // streaming with pointer wrap, no bubbles
    npop = 0;
    ifc.m_ready = 1'b1;
    for (int i = 0; i < 103; i++) begin
      ifc.s_valid = (i < 100);
      ifc.s_data  = 8'(i + 8'h40);
      cyc();
    end
    ifc.s_valid = 1'b0;
    chk("stream_pops", npop, 100);
    chk("stream_level", ifc.level, 0);

    // random backpressure
    cnt = 0; guard = 0;
    ifc.s_valid = 1'b1;
    while (cnt < 200 && guard < 3000) begin
      ifc.s_data  = 8'($urandom);
      ifc.m_ready = 1'($urandom_range(0, 1));
      #1;
      if (ifc.s_ready) cnt++;
      cyc();
      guard++;
    end
    chk("bp_accepted", cnt, 200);
    ifc.s_valid = 1'b0; ifc.m_ready = 1'b1;
    guard = 0;
    while (ifc.level != 0 && guard < 50) begin
      cyc();
      guard++;
    end
    chk("bp_level", ifc.level, 0);
    chk("bp_sb", sb.size(), 0);

    // flush with a read in flight
    ifc.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifc.s_valid = 1'b1; ifc.s_data = 8'(8'h80 + i);
      cyc();
    end
    ifc.s_valid = 1'b0;
    repeat (4) cyc();
    ifc.m_ready = 1'b1;
    #1 chk("fl_issue", ifc.mem_rclken, 1);
    cyc();
    ifc.m_ready = 1'b0; ifc.flush = 1'b1; ifc.s_valid = 1'b1; ifc.s_data = 8'hEE;
    #1;
    chk("fl_wclken", ifc.mem_wclken, 0);
    chk("fl_rclken", ifc.mem_rclken, 0);
    chk("fl_mvalid_pre", ifc.m_valid, 1);
    chk("fl_level_pre", ifc.level, 9);
    cyc();
    ifc.flush = 1'b0; ifc.s_valid = 1'b0;
    #1;
    chk("fl_level", ifc.level, 0);
    chk("fl_mvalid", ifc.m_valid, 0);
    ifc.s_valid = 1'b1; ifc.s_data = 8'h3C;
    cyc();
    ifc.s_valid = 1'b0; ifc.m_ready = 1'b1;
    guard = 0;
    while (!ifc.m_valid && guard < 8) begin
      cyc();
      guard++;
    end
    chk("fl_next_valid", ifc.m_valid, 1);
    chk("fl_next_data", ifc.m_data, 8'h3C);
    cyc();
    #1 chk("fl_final_level", ifc.level, 0);

    // asynchronous reset mid-operation
    ifc.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifc.s_valid = 1'b1; ifc.s_data = 8'(i);
      cyc();
    end
    ifc.s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_level", ifc.level, 0);
    chk("arst_mvalid", ifc.m_valid, 0);
    chk("arst_sready", ifc.s_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", ifc.s_ready, 1);
    chk("arst_rel_mvalid", ifc.m_valid, 0);
    repeat (4) cyc();
    chk("arst_stays_empty", ifc.m_valid, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Single-clock FIFO controller that sequences one fifomem instance configured with registered read (FALLTHROUGH="FALSE").
- Owns the write and read pointers and drives the memory port controls.
- Hides the memory's 1-cycle read latency behind a 2-entry output buffer, so consumers see a first-word-fall-through valid/ready stream at full throughput.
- Sits between a producer and consumer in the same clock domain. Total capacity is DEPTH+2 words.

Parameters:
DATASIZE, 8, data word width; must match the attached fifomem.
ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE.
AFULL_LEVEL, 14, almost_full asserts when level >= AFULL_LEVEL; legal range 1..DEPTH+2.

Ports:
clk  in  1  single clock; also drives fifomem wclk and rclk.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of all contents.
s_valid  in  1  producer word valid.
s_ready  out  1  controller can accept a word.
s_data  in  DATASIZE  producer word.
m_valid  out  1  head word valid.
m_ready  in  1  consumer accepts head word.
m_data  out  DATASIZE  head word.
level  out  ADDRSIZE+2  words held: memory count + rd_pend + out_cnt.
almost_full  out  1  level >= AFULL_LEVEL.
mem_wclken  out  1  to fifomem wclken.
mem_waddr  out  ADDRSIZE  to fifomem waddr.
mem_wdata  out  DATASIZE  to fifomem wdata; equals s_data.
mem_wfull  out  1  to fifomem wfull; equals mem_full.
mem_rclken  out  1  to fifomem rclken.
mem_raddr  out  ADDRSIZE  to fifomem raddr.
mem_rdata  in  DATASIZE  from fifomem rdata; valid the cycle after a rclken edge.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDRSIZE+1 bits each.
  - rd_pend: 1 bit, a read was issued at the previous edge.
  - out_cnt: 0..2.
  - 2-entry output buffer.
- Reset (rst=1, async): ptrs=0, rd_pend=0, out_cnt=0, buffer cleared. While rst=1: m_valid=0, s_ready=0, mem_wclken=0, mem_rclken=0, level=0, almost_full=0. After release: s_ready=1.
- Pointer arithmetic: mem_cnt = wr_ptr - rd_ptr, modulo 2^(ADDRSIZE+1).
  - mem_full = (mem_cnt == DEPTH); mem_empty = (mem_cnt == 0).
  - Addresses are the low ADDRSIZE bits; pointers wrap naturally.
- Write path:
  - s_ready = !mem_full, from registered state only; no combinational dependence on m_ready.
  - push = s_valid & s_ready; mem_wclken = push; mem_waddr = wr_ptr[ADDRSIZE-1:0]; wr_ptr += 1 on push.
- Read issue:
  - credit = 2 - out_cnt - rd_pend + pop, where pop = m_valid & m_ready.
  - issue = !mem_empty & (credit > 0); mem_rclken = issue; mem_raddr = rd_ptr[ADDRSIZE-1:0]; rd_ptr += 1 on issue.
  - rd_pend <= issue.
- Capture: when rd_pend=1, mem_rdata is written into the buffer tail at the edge.
  - out_cnt_next = out_cnt + rd_pend - pop.
  - Invariant out_cnt + rd_pend <= 2; violation is a design error and must be asserted in simulation.
- Output:
  - m_valid = (out_cnt != 0); m_data = buffer head.
  - On pop, the head advances; the second entry, or a simultaneously captured word, becomes the head.
  - m_data holds stable while m_valid=1 and m_ready=0.
- Latency: word pushed at edge E0 → read issued in cycle after E0 → mem_rdata valid after E1 → captured at E2 → m_valid=1 in cycle after E2 (3 edges). Steady-state throughput is 1 word/cycle both sides.
- Boundaries:
  - Read issue uses registered mem_cnt. A word pushed at an edge is readable from the next cycle, which gives no read/write address collision in the same cycle.
  - Memory full with the output stage stalled: s_ready=0. It re-asserts the cycle after an issue frees a slot.
  - Simultaneous push and issue when full: not possible, because push needs !mem_full. When mem_cnt=DEPTH-1, push and issue in the same cycle leave mem_cnt unchanged.
  - Pointer wrap 2*DEPTH→0 must be seamless.
- flush (sync, priority over push/pop/issue): at the edge, ptrs=0, rd_pend=0, out_cnt=0, and any in-flight mem_rdata is discarded. During a flush cycle: mem_wclken=0, mem_rclken=0, and m_valid still reflects the pre-flush state.
- Mid-operation rst: all state clears immediately; the memory array is not cleared but becomes unreachable.
- level is combinational from registered state.

Test Plan:
- Reset/idle: assert rst 3 cycles, release → s_ready=1, m_valid=0, level=0, mem_wclken=mem_rclken=0.
- Single word: push 0xA5 at edge E0, m_ready=1 → m_valid=1 with m_data=0xA5 in cycle after E2, popped once, level returns to 0.
- Fill: m_ready=0, push 0..17 on consecutive cycles.
  - Required: 18 accepted; level=18; s_ready=0 after word 17; almost_full=1 from level 14.
  - Then m_ready=1: pops 0..17 in order, one per cycle.
- Streaming wrap: push and pop every cycle for 100 words (pointers wrap at least 3 times) → output sequence equals input sequence, no bubbles after initial latency.
- Backpressure: random m_ready ~50% with continuous s_valid for 200 words → order preserved, m_data stable while stalled, invariant never violated.
- Flush: with 10 words held and a read in flight, pulse flush → next cycle level=0, m_valid=0. Then push 0x3C → it emerges as the next m_data with no stale word.
